sort_reg_bank: RTL

SORT_REG_BANK -- requirements
Module: sort_reg_bank

---
 rtl/sort_reg_pkg.sv | 19 +
 rtl/sort_cmp.sv | 16 +
 rtl/sort_reg_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sort_reg_pkg.sv
// Shared types and default sizing for the sort register bank.
package sort_reg_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_WRITE = 2'd2
  } swap_state_e;

  // Range check done on 32-bit values so address width never limits the compare.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Combinational a > b comparator; signed when SORT_REG_SIGNED_EN is defined, unsigned otherwise.
module sort_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o
);

`ifdef SORT_REG_SIGNED_EN
  assign gt_o = $signed(a_i) > $signed(b_i);
`else
  assign gt_o = a_i > b_i;
`endif

endmodule

// File: rtl/sort_reg_bank.sv
// Register bank with a 3-state compare-and-swap engine on adjacent entries.
// Compare signedness is selected by SORT_REG_SIGNED_EN (see sort_cmp).
module sort_reg_bank
  import sort_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] swap_idx,
  output logic              swap_busy,
  output logic              swap_done,
  output logic              swapped,
  output logic              swap_err,
  input  logic              count_clr,
  output logic [CNT_W-1:0]  swap_count,
  output swap_state_e       dbg_state
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  swap_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              done_q, done_d;
  logic              swapped_q, swapped_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] idx_hi;
  logic              idx_ok;
  logic              gt;

  assign idx_hi = idx_q + ADDR_W'(1);
  assign idx_ok = addr_ok(32'(idx_q), DEPTH - 1);

  sort_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .gt_o (gt)
  );

  // Request handshake: swap_req is taken on an enabled edge only when the engine
  // is IDLE and no write is presented; otherwise it is dropped, not queued.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    done_d    = 1'b0;
    swapped_d = swapped_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_load) begin
          if (addr_ok(32'(wr_addr), DEPTH)) mem_d[wr_addr] = wr_data;
        end else if (swap_req) begin
          state_d = ST_CMP;
          idx_d   = swap_idx;
        end
      end
      ST_CMP: begin
        a_d     = idx_ok ? mem_q[idx_q]  : '0;
        b_d     = idx_ok ? mem_q[idx_hi] : '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        err_d     = ~idx_ok;
        swapped_d = idx_ok & gt;
        if (idx_ok && gt) begin
          mem_d[idx_q]  = b_q;
          mem_d[idx_hi] = a_q;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (count_clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      swapped_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (enable) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      swapped_q <= swapped_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_data_a  = addr_ok(32'(rd_addr_a), DEPTH) ? mem_q[rd_addr_a] : '0;
  assign rd_data_b  = addr_ok(32'(rd_addr_b), DEPTH) ? mem_q[rd_addr_b] : '0;
  assign swap_busy  = (state_q != ST_IDLE);
  assign swap_done  = done_q;
  assign swapped    = swapped_q;
  assign swap_err   = err_q;
  assign swap_count = cnt_q;
  assign dbg_state  = state_q;

endmodule
